id_ex: RTL and testbench
========================

ID_EX -- requirements
Module: id_ex

Interface
REQ-001 Parameter: WIDTH, 32, datapath width; register-address width is log2(WIDTH) = 5.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 inst_i, inst_addr_i  input  WIDTH each  instruction word and its address from the decode stage.
REQ-006 op1_i, op2_i, base_addr_i, addr_offset_i  input  WIDTH each  decoded operands and branch/memory address terms.
REQ-007 rd_addr_i  input  5  destination register; regs_wen_i  input  1  register write enable.
REQ-008 mem_rd_req_i  input  1  instruction is a load.
REQ-009 rs1_addr_i, rs2_addr_i  input  5 each  source registers of the instruction currently in decode.
REQ-010 flush_i  input  1  taken jump/branch from execute; kills the instruction entering execute.
REQ-011 inst_o, inst_addr_o, op1_o, op2_o, base_addr_o, addr_offset_o  output  WIDTH each  registered copies for execute.
REQ-012 rd_addr_o  output  5; regs_wen_o  output  1; mem_rd_req_o  output  1  registered copies.
REQ-013 stall_o  output  1  combinational; instructs fetch and the IF/ID register to hold for this cycle.
REQ-014 bubble_cnt_o  output  WIDTH  count of bubbles inserted since reset.

Function
REQ-015 The block is a single-cycle pipeline register: in a normal cycle every *_o takes the value of its *_i at the rising edge, giving 1-cycle latency.
REQ-016 hazard = mem_rd_req_o & regs_wen_o & (rd_addr_o != 0) & ((rd_addr_o == rs1_addr_i) | (rd_addr_o == rs2_addr_i)).
REQ-017 stall_o = hazard & ~flush_i, purely combinational with no register delay.
REQ-018 Edge priority: rst, then flush_i, then hazard, then the normal load.
REQ-019 On flush_i = 1 or hazard = 1, the block loads a bubble: inst_o = 32'h0000_0013, and inst_addr_o, op1_o, op2_o, base_addr_o, addr_offset_o, rd_addr_o, regs_wen_o and mem_rd_req_o are all 0.
REQ-020 A bubble lasts exactly one cycle: after a bubble mem_rd_req_o = 0, so hazard deasserts and the held decode instruction is loaded on the next edge.
REQ-021 Back-to-back loads with a dependency (load x1; load x2,0(x1)) produce exactly one bubble; the second load then itself becomes the hazard source.
REQ-022 A dependency on x0 never stalls, including when rd_addr_o == 0 with regs_wen_o = 1.
REQ-023 A non-load producer (mem_rd_req_o = 0) never stalls; forwarding is not handled here.
REQ-024 When flush_i and hazard occur together, the flush bubble is loaded, stall_o = 0, and bubble_cnt_o increments by 1, not 2.
REQ-025 bubble_cnt_o increments by 1 on every edge that loads a bubble caused by hazard or flush_i (not rst).
REQ-026 bubble_cnt_o saturates at all-ones and does not wrap.

Reset
REQ-027 While rst = 1 at an edge, every output register loads the bubble values of REQ-019 and bubble_cnt_o loads 0.
REQ-028 stall_o evaluates to 0 in the cycle after reset because mem_rd_req_o = 0.
REQ-029 Reset asserted mid-stall discards the pending hazard; no bubble is counted and the held instruction is not loaded by this block.
REQ-030 There is no asynchronous reset path; rst has no effect between clock edges.

Verification
REQ-031 Pass-through: inst_i = 32'h0020_8133 (add x2,x1,x2), op1_i = 5, op2_i = 7, rd_addr_i = 2, regs_wen_i = 1 -> next cycle outputs are equal, stall_o = 0, bubble_cnt_o = 0.
REQ-032 Load-use: the register holds lw x5 (mem_rd_req_o = 1, rd_addr_o = 5) and decode presents rs1_addr_i = 5 -> stall_o = 1 for exactly one cycle, next inst_o = 32'h0000_0013, bubble_cnt_o = 1, then the dependent instruction appears.
REQ-033 x0 and non-load producers: lw x0 with rs1_addr_i = 0 -> stall_o = 0; add x5 followed by rs2_addr_i = 5 -> stall_o = 0.
REQ-034 Flush plus hazard in the same cycle -> stall_o = 0, a single bubble, bubble_cnt_o increments by exactly 1.
REQ-035 Reset mid-stall: rst = 1 while stall_o = 1 -> all outputs 0 except inst_o = 32'h0000_0013, bubble_cnt_o = 0, and stall_o = 0 the following cycle.
REQ-036 Saturation: force bubble_cnt_o to 32'hFFFF_FFFE, then apply 3 flushes -> bubble_cnt_o reads 32'hFFFF_FFFF and stays there.

Source files
------------

// File: rtl/id_ex_if.sv
// ID/EX pipeline-register bus.
// Groups the decode-side inputs (*_i) and the execute-side registered
// copies (*_o) of the ID/EX stage, plus the combinational load-use stall.
//   slave  : the ID/EX register itself (reads *_i, drives *_o and stall_o)
//   master : the surrounding pipeline (drives *_i, reads *_o and stall_o)
// WIDTH is the datapath width; register addresses are log2(WIDTH) bits.
interface id_ex_if #(
    parameter int WIDTH = 32
);
    localparam int AW = $clog2(WIDTH);

    // decode-side inputs
    logic [WIDTH-1:0] inst_i;
    logic [WIDTH-1:0] inst_addr_i;
    logic [WIDTH-1:0] op1_i;
    logic [WIDTH-1:0] op2_i;
    logic [WIDTH-1:0] base_addr_i;
    logic [WIDTH-1:0] addr_offset_i;
    logic [AW-1:0]    rd_addr_i;
    logic             regs_wen_i;
    logic             mem_rd_req_i;
    logic [AW-1:0]    rs1_addr_i;
    logic [AW-1:0]    rs2_addr_i;
    logic             flush_i;

    // execute-side outputs
    logic [WIDTH-1:0] inst_o;
    logic [WIDTH-1:0] inst_addr_o;
    logic [WIDTH-1:0] op1_o;
    logic [WIDTH-1:0] op2_o;
    logic [WIDTH-1:0] base_addr_o;
    logic [WIDTH-1:0] addr_offset_o;
    logic [AW-1:0]    rd_addr_o;
    logic             regs_wen_o;
    logic             mem_rd_req_o;
    logic             stall_o;
    logic [WIDTH-1:0] bubble_cnt_o;

    modport slave (
        input  inst_i, inst_addr_i, op1_i, op2_i, base_addr_i, addr_offset_i,
               rd_addr_i, regs_wen_i, mem_rd_req_i, rs1_addr_i, rs2_addr_i, flush_i,
        output inst_o, inst_addr_o, op1_o, op2_o, base_addr_o, addr_offset_o,
               rd_addr_o, regs_wen_o, mem_rd_req_o, stall_o, bubble_cnt_o
    );

    modport master (
        output inst_i, inst_addr_i, op1_i, op2_i, base_addr_i, addr_offset_i,
               rd_addr_i, regs_wen_i, mem_rd_req_i, rs1_addr_i, rs2_addr_i, flush_i,
        input  inst_o, inst_addr_o, op1_o, op2_o, base_addr_o, addr_offset_o,
               rd_addr_o, regs_wen_o, mem_rd_req_o, stall_o, bubble_cnt_o
    );
endinterface

// File: rtl/id_ex.sv
// ID/EX pipeline register with load-use hazard detection.
// Ports:
//   clk  - rising-edge clock for all state
//   rst  - synchronous, active-high reset (no effect between edges)
//   bus  - id_ex_if.slave: decode inputs, registered execute outputs,
//          combinational stall_o and saturating bubble counter.
// A normal edge copies every *_i into its *_o. When a flush arrives or the
// instruction in execute is a load whose destination is read by the
// instruction in decode, a bubble (canonical NOP, all controls cleared) is
// loaded instead. The bubble clears mem_rd_req_o, so the hazard lasts one
// cycle and the held decode instruction enters on the following edge.
module id_ex #(
    parameter int WIDTH = 32
) (
    input logic   clk,
    input logic   rst,
    id_ex_if.slave bus
);
    localparam int AW = $clog2(WIDTH);
    // addi x0,x0,0
    localparam logic [WIDTH-1:0] NOP_INST = WIDTH'(32'h0000_0013);

    logic [WIDTH-1:0] inst_r;
    logic [WIDTH-1:0] inst_addr_r;
    logic [WIDTH-1:0] op1_r;
    logic [WIDTH-1:0] op2_r;
    logic [WIDTH-1:0] base_addr_r;
    logic [WIDTH-1:0] addr_offset_r;
    logic [AW-1:0]    rd_addr_r;
    logic             regs_wen_r;
    logic             mem_rd_req_r;
    logic [WIDTH-1:0] bubble_cnt_r;

    logic             hazard_s;
    logic             bubble_s;
    logic [WIDTH-1:0] bubble_cnt_next_s;

    // Load-use detection against the load currently in execute; x0 never stalls.
    always_comb begin
        hazard_s = 1'b0;
        if (mem_rd_req_r && regs_wen_r && (rd_addr_r != {AW{1'b0}}) &&
            ((rd_addr_r == bus.rs1_addr_i) || (rd_addr_r == bus.rs2_addr_i))) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = 1'b0;
        end
    end

    // A flush already kills the entering instruction, so it masks the stall
    // and both causes together yield a single bubble.
    always_comb begin
        bubble_s = bus.flush_i | hazard_s;
        bus.stall_o = hazard_s & ~bus.flush_i;
    end

    // Saturating increment of the bubble counter.
    always_comb begin
        bubble_cnt_next_s = bubble_cnt_r;
        if (bubble_cnt_r != {WIDTH{1'b1}}) begin
            bubble_cnt_next_s = bubble_cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            bubble_cnt_next_s = bubble_cnt_r;
        end
    end

    // Pipeline register: reset, then bubble (flush/hazard), then normal load.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_r        <= NOP_INST;
            inst_addr_r   <= {WIDTH{1'b0}};
            op1_r         <= {WIDTH{1'b0}};
            op2_r         <= {WIDTH{1'b0}};
            base_addr_r   <= {WIDTH{1'b0}};
            addr_offset_r <= {WIDTH{1'b0}};
            rd_addr_r     <= {AW{1'b0}};
            regs_wen_r    <= 1'b0;
            mem_rd_req_r  <= 1'b0;
            bubble_cnt_r  <= {WIDTH{1'b0}};
        end else if (bubble_s) begin
            inst_r        <= NOP_INST;
            inst_addr_r   <= {WIDTH{1'b0}};
            op1_r         <= {WIDTH{1'b0}};
            op2_r         <= {WIDTH{1'b0}};
            base_addr_r   <= {WIDTH{1'b0}};
            addr_offset_r <= {WIDTH{1'b0}};
            rd_addr_r     <= {AW{1'b0}};
            regs_wen_r    <= 1'b0;
            mem_rd_req_r  <= 1'b0;
            bubble_cnt_r  <= bubble_cnt_next_s;
        end else begin
            inst_r        <= bus.inst_i;
            inst_addr_r   <= bus.inst_addr_i;
            op1_r         <= bus.op1_i;
            op2_r         <= bus.op2_i;
            base_addr_r   <= bus.base_addr_i;
            addr_offset_r <= bus.addr_offset_i;
            rd_addr_r     <= bus.rd_addr_i;
            regs_wen_r    <= bus.regs_wen_i;
            mem_rd_req_r  <= bus.mem_rd_req_i;
            bubble_cnt_r  <= bubble_cnt_r;
        end
    end

    // Registered outputs to execute.
    always_comb begin
        bus.inst_o        = inst_r;
        bus.inst_addr_o   = inst_addr_r;
        bus.op1_o         = op1_r;
        bus.op2_o         = op2_r;
        bus.base_addr_o   = base_addr_r;
        bus.addr_offset_o = addr_offset_r;
        bus.rd_addr_o     = rd_addr_r;
        bus.regs_wen_o    = regs_wen_r;
        bus.mem_rd_req_o  = mem_rd_req_r;
        bus.bubble_cnt_o  = bubble_cnt_r;
    end
endmodule

// File: tb/tb_id_ex.sv
// Directed testbench for id_ex: pass-through, load-use stall, x0 and
// non-load producers, back-to-back loads, flush+hazard, reset mid-stall and
// bubble-counter saturation. Expected values are hand-computed constants.
module tb_id_ex;
    logic clk;
    logic rst;
    int   n_checks_r;
    int   n_fail_r;

    localparam logic [31:0] NOP = 32'h0000_0013;

    id_ex_if #(.WIDTH(32)) bus ();

    id_ex #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks_r++;
        if (obs !== exp) begin
            n_fail_r++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One rising edge, then return at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] addr,
                         input logic [31:0] op1, input logic [31:0] op2,
                         input logic [4:0] rd, input logic wen, input logic mem,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic flush);
        bus.inst_i        = inst;
        bus.inst_addr_i   = addr;
        bus.op1_i         = op1;
        bus.op2_i         = op2;
        bus.base_addr_i   = addr + 32'h0000_1000;
        bus.addr_offset_i = op2 + 32'h0000_0004;
        bus.rd_addr_i     = rd;
        bus.regs_wen_i    = wen;
        bus.mem_rd_req_i  = mem;
        bus.rs1_addr_i    = rs1;
        bus.rs2_addr_i    = rs2;
        bus.flush_i       = flush;
        #1;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, "_inst"}, bus.inst_o, NOP);
        check({tag, "_addr"}, bus.inst_addr_o, 32'h0);
        check({tag, "_op1"}, bus.op1_o, 32'h0);
        check({tag, "_op2"}, bus.op2_o, 32'h0);
        check({tag, "_base"}, bus.base_addr_o, 32'h0);
        check({tag, "_off"}, bus.addr_offset_o, 32'h0);
        check({tag, "_rd"}, {27'd0, bus.rd_addr_o}, 32'h0);
        check({tag, "_wen"}, {31'd0, bus.regs_wen_o}, 32'h0);
        check({tag, "_mem"}, {31'd0, bus.mem_rd_req_o}, 32'h0);
    endtask

    initial begin
        n_checks_r = 0;
        n_fail_r   = 0;
        rst = 1'b1;
        // garbage on the inputs must not reach the outputs during reset
        drive(32'hDEAD_BEEF, 32'h1234_5678, 32'h1, 32'h2, 5'd9, 1'b1, 1'b1, 5'd9, 5'd9, 1'b0);
        @(negedge clk);
        tick();
        check_bubble("reset");
        check("reset_cnt", bus.bubble_cnt_o, 32'h0);
        check("reset_stall", {31'd0, bus.stall_o}, 32'h0);

        // pass-through: add x2,x1,x2
        rst = 1'b0;
        drive(32'h0020_8133, 32'h0000_0100, 32'd5, 32'd7, 5'd2, 1'b1, 1'b0, 5'd1, 5'd2, 1'b0);
        check("pt_stall_pre", {31'd0, bus.stall_o}, 32'h0);
        tick();
        check("pt_inst", bus.inst_o, 32'h0020_8133);
        check("pt_addr", bus.inst_addr_o, 32'h0000_0100);
        check("pt_op1", bus.op1_o, 32'd5);
        check("pt_op2", bus.op2_o, 32'd7);
        check("pt_base", bus.base_addr_o, 32'h0000_1100);
        check("pt_off", bus.addr_offset_o, 32'd11);
        check("pt_rd", {27'd0, bus.rd_addr_o}, 32'd2);
        check("pt_wen", {31'd0, bus.regs_wen_o}, 32'd1);
        check("pt_mem", {31'd0, bus.mem_rd_req_o}, 32'd0);
        check("pt_cnt", bus.bubble_cnt_o, 32'd0);
        // non-load producer x2 read by decode: no stall
        check("nonload_stall", {31'd0, bus.stall_o}, 32'h0);

        // load-use: lw x5,0(x1) then add x6,x5,x0
        drive(32'h0000_A283, 32'h0000_0104, 32'd0, 32'd0, 5'd5, 1'b1, 1'b1, 5'd1, 5'd0, 1'b0);
        tick();
        check("lu_mem", {31'd0, bus.mem_rd_req_o}, 32'd1);
        drive(32'h0002_8333, 32'h0000_0108, 32'd11, 32'd22, 5'd6, 1'b1, 1'b0, 5'd5, 5'd0, 1'b0);
        check("lu_stall", {31'd0, bus.stall_o}, 32'd1);
        tick();
        check_bubble("lu_bubble");
        check("lu_cnt", bus.bubble_cnt_o, 32'd1);
        check("lu_stall_after", {31'd0, bus.stall_o}, 32'd0);
        tick();
        check("lu_dep_inst", bus.inst_o, 32'h0002_8333);
        check("lu_dep_rd", {27'd0, bus.rd_addr_o}, 32'd6);
        check("lu_dep_op1", bus.op1_o, 32'd11);
        check("lu_dep_cnt", bus.bubble_cnt_o, 32'd1);

        // lw x0 followed by a reader of x0: no stall
        drive(32'h0000_2003, 32'h0000_010C, 32'd0, 32'd0, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0);
        tick();
        drive(32'h0000_0033, 32'h0000_0110, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
        check("x0_stall", {31'd0, bus.stall_o}, 32'd0);

        // back-to-back loads: lw x1 ; lw x2,0(x1)
        drive(32'h0000_2083, 32'h0000_0114, 32'd0, 32'd0, 5'd1, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0);
        tick();
        drive(32'h0000_A103, 32'h0000_0118, 32'd3, 32'd0, 5'd2, 1'b1, 1'b1, 5'd1, 5'd0, 1'b0);
        check("b2b_stall", {31'd0, bus.stall_o}, 32'd1);
        tick();
        check("b2b_bubble", bus.inst_o, NOP);
        check("b2b_cnt", bus.bubble_cnt_o, 32'd2);
        check("b2b_stall_after", {31'd0, bus.stall_o}, 32'd0);
        tick();
        check("b2b_second", bus.inst_o, 32'h0000_A103);
        check("b2b_second_mem", {31'd0, bus.mem_rd_req_o}, 32'd1);
        // second load becomes the hazard source for a reader of x2
        drive(32'h0020_01B3, 32'h0000_011C, 32'd4, 32'd5, 5'd3, 1'b1, 1'b0, 5'd0, 5'd2, 1'b0);
        check("b2b_src_stall", {31'd0, bus.stall_o}, 32'd1);

        // flush together with hazard: single bubble, no stall
        bus.flush_i = 1'b1;
        #1;
        check("fh_stall", {31'd0, bus.stall_o}, 32'd0);
        tick();
        check_bubble("fh_bubble");
        check("fh_cnt", bus.bubble_cnt_o, 32'd3);

        // lw x7, then reader of x7, then reset while stalled
        drive(32'h0000_2383, 32'h0000_0200, 32'd0, 32'd0, 5'd7, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0);
        tick();
        drive(32'h0003_8433, 32'h0000_0204, 32'd8, 32'd9, 5'd8, 1'b1, 1'b0, 5'd7, 5'd0, 1'b0);
        check("rs_stall_pre", {31'd0, bus.stall_o}, 32'd1);
        rst = 1'b1;
        #1;
        check("rs_stall_async", {31'd0, bus.stall_o}, 32'd1);
        tick();
        check_bubble("rs_bubble");
        check("rs_cnt", bus.bubble_cnt_o, 32'd0);
        rst = 1'b0;
        #1;
        check("rs_stall_after", {31'd0, bus.stall_o}, 32'd0);
        tick();
        check("rs_held_load", bus.inst_o, 32'h0003_8433);

        // saturation of the bubble counter
        force dut.bubble_cnt_r = 32'hFFFF_FFFE;
        #1;
        release dut.bubble_cnt_r;
        #1;
        check("sat_forced", bus.bubble_cnt_o, 32'hFFFF_FFFE);
        for (int i = 0; i < 3; i++) begin
            drive(32'h0000_0033, 32'h0000_0300, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1);
            tick();
            check($sformatf("sat_flush%0d", i), bus.bubble_cnt_o, 32'hFFFF_FFFF);
        end
        drive(32'h0000_0033, 32'h0000_0300, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        tick();
        check("sat_hold", bus.bubble_cnt_o, 32'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks_r, n_fail_r);
        $finish;
    end
endmodule
